fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter for the asynchronous FIFO. It shares the FIFO's single write port between NUM_REQ producers in the write-clock domain. Each producer gets a valid/ready handshake; the arbiter drives the FIFO's wr_en/data_in and honours fifo_full. It sits between the producer blocks and the FIFO write side, on the same wrclk/wrst_n as the FIFO write logic.

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/fifo_wr_arbiter_if.sv | 30 +++
 rtl/fifo_rr_picker.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 148 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and widths for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;

    localparam int unsigned NUM_REQ_DEF    = 4;
    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned MAX_BURST_DEF  = 4;
    localparam int unsigned ID_W           = $clog2(NUM_REQ_DEF);
    localparam int unsigned WR_COUNT_W     = 16;
    localparam int unsigned BURST_CNT_W    = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-write-side bundle for fifo_wr_arbiter.
// master: producers + FIFO side (drives requests and fifo_full).
// slave : the arbiter (drives ready, wr_en/data_in, grant status, wr_count).
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0]       req_data;
    logic [NUM_REQ-1:0]                  req_last;
    logic [NUM_REQ-1:0]                  req_ready;
    logic                                fifo_full;
    logic                                wr_en;
    logic [DATA_WIDTH-1:0]               data_in;
    logic                                grant_valid;
    logic [ID_W-1:0]                     grant_id;
    logic [fifo_arb_pkg::WR_COUNT_W-1:0] wr_count;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, wr_en, data_in, grant_valid, grant_id, wr_count
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, wr_en, data_in, grant_valid, grant_id, wr_count
    );
endinterface

// File: rtl/fifo_rr_picker.sv
// Combinational round-robin picker: finds the first set request searching
// upward from last+1 (mod NUM_REQ), wrapping round to last itself.
// Ports: req (request vector), last (previous owner) -> found, pick.
module fifo_rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               found,
    output logic [ID_W-1:0]    pick
);

    // Walk distances from farthest to nearest so the nearest hit wins.
    always_comb begin
        logic [ID_W-1:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = int'(NUM_REQ); i >= 1; i--) begin
            idx = ID_W'((int'(last) + i) % int'(NUM_REQ));
            if (req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NUM_REQ producers.
// Ports: wrclk, wrst_n (async active-low), bus (fifo_wr_arbiter_if.slave).
// wr_en, req_ready, data_in and grant_valid are combinational from the
// registered state/grant and fifo_full, so a full FIFO is never written.
// Optional macro FIFO_ARB_BURST_EN: owner keeps the grant until req_last,
// MAX_BURST beats or a cycle with its valid low; otherwise one beat per grant.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned MAX_BURST  = MAX_BURST_DEF
) (
    input  logic              wrclk,
    input  logic              wrst_n,
    fifo_wr_arbiter_if.slave  bus
);

    localparam int unsigned GID_W = $clog2(NUM_REQ);

    arb_state_e              state, state_nxt;
    logic [GID_W-1:0]        grant_id, grant_id_nxt;
    logic [GID_W-1:0]        last_owner, last_owner_nxt;
    logic [GID_W-1:0]        pick_last, pick;
    logic                    found;
    logic                    owner_valid;
    logic                    accept;
    logic                    release_now;
    logic [WR_COUNT_W-1:0]   wr_count;
    logic [NUM_REQ-1:0]      ready;
    logic [DATA_WIDTH-1:0]   data_sel;

`ifdef FIFO_ARB_BURST_EN
    logic [BURST_CNT_W-1:0]  burst_cnt, burst_cnt_nxt;
    logic                    burst_end;
    assign burst_end = bus.req_last[grant_id]
                     | (burst_cnt == BURST_CNT_W'(MAX_BURST - 1));
`else
    logic unused_last;
    assign unused_last = ^bus.req_last;
`endif

    assign owner_valid = bus.req_valid[grant_id];
    assign accept      = (state == GRANT) & owner_valid & ~bus.fifo_full;
    // After an accept the owner becomes last_owner on this same edge, so
    // the re-pick must already search from the owner.
    assign pick_last   = accept ? grant_id : last_owner;

    fifo_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (GID_W)
    ) u_picker (
        .req   (bus.req_valid),
        .last  (pick_last),
        .found (found),
        .pick  (pick)
    );

    // State, grant and counters.
    always_ff @(posedge wrclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_owner <= GID_W'(NUM_REQ - 1);
            wr_count   <= '0;
`ifdef FIFO_ARB_BURST_EN
            burst_cnt  <= '0;
`endif
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_id_nxt;
            last_owner <= last_owner_nxt;
            if (accept) begin
                wr_count <= wr_count + 1'b1;
            end
`ifdef FIFO_ARB_BURST_EN
            burst_cnt  <= burst_cnt_nxt;
`endif
        end
    end

    // Next-state: grant load, hold/stall and release.
    always_comb begin
        state_nxt      = state;
        grant_id_nxt   = grant_id;
        last_owner_nxt = last_owner;
        release_now    = 1'b0;
`ifdef FIFO_ARB_BURST_EN
        burst_cnt_nxt  = burst_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt    = GRANT;
                    grant_id_nxt = pick;
`ifdef FIFO_ARB_BURST_EN
                    burst_cnt_nxt = '0;
`endif
                end
            end
            GRANT: begin
                if (bus.fifo_full) begin
                    release_now = 1'b0;
                end else if (!owner_valid) begin
                    release_now = 1'b1;
`ifdef FIFO_ARB_BURST_EN
                end else if (!burst_end) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
`endif
                end else begin
                    last_owner_nxt = grant_id;
                    release_now    = 1'b1;
                end
                if (release_now) begin
                    if (found) begin
                        grant_id_nxt = pick;
                    end else begin
                        state_nxt = IDLE;
                    end
`ifdef FIFO_ARB_BURST_EN
                    burst_cnt_nxt = '0;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Owner-select for ready and write data.
    always_comb begin
        ready    = '0;
        data_sel = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_id == GID_W'(i)) begin
                ready[i] = (state == GRANT) & ~bus.fifo_full;
                data_sel = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.req_ready   = ready;
    assign bus.wr_en       = accept;
    assign bus.data_in     = data_sel;
    assign bus.grant_valid = (state == GRANT);
    assign bus.grant_id    = grant_id;
    assign bus.wr_count    = wr_count;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a scoreboard of expected writes.
module tb_fifo_wr_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (4)
    ) dut (
        .wrclk  (clk),
        .wrst_n (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] data);
        beat_t b;
        b.id   = id;
        b.data = data;
        exp_q.push_back(b);
    endtask

    task automatic set_data(input logic [7:0] base);
        for (int i = 0; i < int'(NR); i++) begin
            bus.req_data[i*DW +: DW] = base + 8'(i);
        end
    endtask

    // n consecutive write cycles; returns just after the edge accepting the last.
    task automatic expect_beats(input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk(nm, 32'(bus.wr_en), 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every FIFO write is matched against the head of the queue.
    always @(negedge clk) begin : monitor
        beat_t e;
        if (rst_n && bus.wr_en) begin
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_grant_id", 32'(bus.grant_id), 32'(e.id));
                chk("wr_data", 32'(bus.data_in), 32'(e.data));
                chk("wr_ready", 32'(bus.req_ready), 32'(4'b0001 << e.id));
                chk("wr_not_full", 32'(bus.fifo_full), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst_wr_count", 32'(bus.wr_count), 32'd0);
        rst_n = 1'b1;

        // Single beat from requester 0 after reset, one-cycle bubble.
        @(posedge clk); #1;
        set_data(8'hA5);
        bus.req_valid = 4'b0001;
        push(2'd0, 8'hA5);
        @(negedge clk);
        chk("t1_bubble", 32'(bus.wr_en), 32'd0);
        expect_beats(1, "t1_wr_en");
        bus.req_valid = '0;
        @(negedge clk);
        chk("t1_wr_count", 32'(bus.wr_count), 32'd1);
        chk("t1_grant_id", 32'(bus.grant_id), 32'd0);
        @(negedge clk);
        chk("t1_idle", 32'(bus.grant_valid), 32'd0);

        // All four valid: strict rotation, no idle cycles after the first.
        pulse_reset();
        @(posedge clk); #1;
        set_data(8'h10);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) push(2'(k), 8'h10 + 8'(k % 4));
        @(negedge clk);
        chk("t2_bubble", 32'(bus.wr_en), 32'd0);
        expect_beats(8, "t2_stream");
        bus.req_valid = '0;
        @(negedge clk);
        chk("t2_wr_count", 32'(bus.wr_count), 32'd8);
        @(negedge clk);

        // fifo_full for 3 cycles mid-stream: stall, grant held on owner 2.
        @(posedge clk); #1;
        set_data(8'h30);
        bus.req_valid = 4'b1111;
        push(2'd0, 8'h30); push(2'd1, 8'h31); push(2'd2, 8'h32); push(2'd3, 8'h33);
        @(negedge clk);
        chk("t3_bubble", 32'(bus.wr_en), 32'd0);
        expect_beats(2, "t3_pre_full");
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_full_wr_en", 32'(bus.wr_en), 32'd0);
            chk("t3_full_ready", 32'(bus.req_ready), 32'd0);
            chk("t3_full_grant", 32'(bus.grant_id), 32'd2);
            chk("t3_full_gvalid", 32'(bus.grant_valid), 32'd1);
        end
        @(posedge clk); #1;
        bus.fifo_full = 1'b0;
        expect_beats(2, "t3_post_full");
        bus.req_valid = '0;
        @(negedge clk);
        chk("t3_wr_count", 32'(bus.wr_count), 32'd12);
        @(negedge clk);

        // Owner 0 drops valid while granted; grant rotates to requester 1.
        @(posedge clk); #1;
        set_data(8'h50);
        bus.req_valid = 4'b0001;
        @(posedge clk); #1;
        bus.req_valid = 4'b0010;
        push(2'd1, 8'h51);
        @(negedge clk);
        chk("t4_drop_wr_en", 32'(bus.wr_en), 32'd0);
        chk("t4_drop_grant", 32'(bus.grant_id), 32'd0);
        chk("t4_drop_gvalid", 32'(bus.grant_valid), 32'd1);
        expect_beats(1, "t4_next_owner");
        bus.req_valid = '0;
        @(negedge clk);
        chk("t4_wr_count", 32'(bus.wr_count), 32'd13);
        @(negedge clk);

        // Reset mid-stream: in-flight beat of owner 3 is never written.
        @(posedge clk); #1;
        set_data(8'h70);
        bus.req_valid = 4'b1111;
        push(2'd2, 8'h72);
        @(negedge clk);
        chk("t5_bubble", 32'(bus.wr_en), 32'd0);
        @(negedge clk);
        chk("t5_beat", 32'(bus.wr_en), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("t5_rst_ready", 32'(bus.req_ready), 32'd0);
        chk("t5_rst_gvalid", 32'(bus.grant_valid), 32'd0);
        chk("t5_rst_count", 32'(bus.wr_count), 32'd0);
        push(2'd0, 8'h70);
        @(negedge clk);
        rst_n = 1'b1;
        expect_beats(1, "t5_after_rst");
        bus.req_valid = '0;
        @(negedge clk);
        chk("t5_wr_count", 32'(bus.wr_count), 32'd1);
        @(negedge clk);

`ifdef FIFO_ARB_BURST_EN
        // Burst capped at MAX_BURST=4, then requester 2 takes over.
        pulse_reset();
        @(posedge clk); #1;
        set_data(8'h90);
        bus.req_valid = 4'b0110;
        for (int k = 0; k < 4; k++) push(2'd1, 8'h91);
        push(2'd2, 8'h92);
        @(negedge clk);
        chk("t6_bubble", 32'(bus.wr_en), 32'd0);
        expect_beats(5, "t6_burst");
        bus.req_valid = '0;
        @(negedge clk);
        chk("t6_wr_count", 32'(bus.wr_count), 32'd5);
        @(negedge clk);

        // req_last on beat 2 ends the burst early.
        pulse_reset();
        @(posedge clk); #1;
        set_data(8'hB0);
        bus.req_valid = 4'b0110;
        push(2'd1, 8'hB1); push(2'd1, 8'hB1); push(2'd2, 8'hB2);
        @(negedge clk);
        expect_beats(1, "t7_beat1");
        bus.req_last = 4'b0010;
        expect_beats(1, "t7_beat2_last");
        bus.req_last = '0;
        expect_beats(1, "t7_next_owner");
        bus.req_valid = '0;
        @(negedge clk);
        chk("t7_wr_count", 32'(bus.wr_count), 32'd3);
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
